// File: rtl/i2c_passthru_bus_recovery.sv
// Bus-recovery sequencer for one side of the I2C passthru: clocks SCL while SDA is stuck low,
// then issues a STOP. It only requests open-drain pull-downs; the pad logic ORs them onto the bus.
module i2c_passthru_bus_recovery #(
   parameter int F_REF_T_HALF        = 20,
   parameter int F_REF_T_STRETCH_MAX = 200,
   parameter int NUM_PULSES          = 9,
   parameter int MAX_ATTEMPTS        = 3,
   parameter int WIDTH_TIMER         = 8,
   parameter int WIDTH_PULSE         = 4,
   parameter int WIDTH_ATTEMPT       = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_f_ref,
   input  logic i_stuck,
   input  logic i_sda,
   input  logic i_scl,
   output logic o_scl_low,
   output logic o_sda_low,
   output logic o_busy,
   output logic o_recovered,
   output logic o_fail
);

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_START      = 4'd1,
      ST_SCL_CHECK  = 4'd2,
      ST_PULSE_LOW  = 4'd3,
      ST_PULSE_REL  = 4'd4,
      ST_PULSE_HIGH = 4'd5,
      ST_STOP_A     = 4'd6,
      ST_STOP_B     = 4'd7,
      ST_STOP_C     = 4'd8,
      ST_DONE       = 4'd9,
      ST_FAIL       = 4'd10
   } state_t;

   localparam logic [WIDTH_TIMER-1:0]   T_HALF_C       = WIDTH_TIMER'(F_REF_T_HALF);
   localparam logic [WIDTH_TIMER-1:0]   T_STRETCH_C    = WIDTH_TIMER'(F_REF_T_STRETCH_MAX);
   localparam logic [WIDTH_TIMER-1:0]   TIMER_ZERO_C   = WIDTH_TIMER'(32'd0);
   localparam logic [WIDTH_TIMER-1:0]   TIMER_ONE_C    = WIDTH_TIMER'(32'd1);
   localparam logic [WIDTH_PULSE-1:0]   PULSE_ZERO_C   = WIDTH_PULSE'(32'd0);
   localparam logic [WIDTH_PULSE-1:0]   PULSE_ONE_C    = WIDTH_PULSE'(32'd1);
   localparam logic [WIDTH_PULSE-1:0]   PULSE_MAX_C    = WIDTH_PULSE'(NUM_PULSES);
   localparam logic [WIDTH_ATTEMPT-1:0] ATTEMPT_ZERO_C = WIDTH_ATTEMPT'(32'd0);
   localparam logic [WIDTH_ATTEMPT-1:0] ATTEMPT_ONE_C  = WIDTH_ATTEMPT'(32'd1);
   localparam logic [WIDTH_ATTEMPT-1:0] ATTEMPT_MAX_C  = WIDTH_ATTEMPT'(MAX_ATTEMPTS);

   state_t                   state_r, state_s;
   logic [WIDTH_TIMER-1:0]   timer_r, load_val_s;
   logic [WIDTH_PULSE-1:0]   pulse_r, pulse_s, pulse_inc_s;
   logic [WIDTH_ATTEMPT-1:0] attempt_r, attempt_s, attempt_inc_s;
   logic                     prev_f_ref_r, prev_stuck_r;
   logic                     tick_s, tc_s, stuck_rise_s, load_s, recovered_s;

   assign tick_s        = i_f_ref & ~prev_f_ref_r;
   assign tc_s          = (timer_r == TIMER_ZERO_C);
   assign stuck_rise_s  = i_stuck & ~prev_stuck_r;
   assign pulse_inc_s   = pulse_r + PULSE_ONE_C;
   assign attempt_inc_s = attempt_r + ATTEMPT_ONE_C;
   assign load_s        = (state_s != state_r);

   // Edge-detect history; sampled through reset so a stuck flag held across reset is not a new edge.
   always_ff @(posedge i_clk) begin
      prev_f_ref_r <= i_f_ref;
      prev_stuck_r <= i_stuck;
   end

   // Next-state, counter updates and the success strobe.
   always_comb begin
      state_s     = state_r;
      pulse_s     = pulse_r;
      attempt_s   = attempt_r;
      recovered_s = 1'b0;
      if (!i_en) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (stuck_rise_s) begin
                  state_s   = ST_START;
                  attempt_s = ATTEMPT_ZERO_C;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_START: begin
               if (!i_scl) begin
                  state_s = ST_SCL_CHECK;
               end else if (i_sda) begin
                  state_s = ST_STOP_A;
               end else begin
                  state_s = ST_PULSE_LOW;
                  pulse_s = PULSE_ZERO_C;
               end
            end
            ST_SCL_CHECK: begin
               if (i_scl)     state_s = ST_START;
               else if (tc_s) state_s = ST_FAIL;
               else           state_s = ST_SCL_CHECK;
            end
            ST_PULSE_LOW: begin
               if (tc_s) state_s = ST_PULSE_REL;
               else      state_s = ST_PULSE_LOW;
            end
            ST_PULSE_REL: begin
               if (i_scl)     state_s = ST_PULSE_HIGH;
               else if (tc_s) state_s = ST_FAIL;
               else           state_s = ST_PULSE_REL;
            end
            ST_PULSE_HIGH: begin
               if (tc_s) begin
                  pulse_s = pulse_inc_s;
                  if (i_sda) begin
                     state_s = ST_STOP_A;
                  end else if (pulse_inc_s == PULSE_MAX_C) begin
                     attempt_s = attempt_inc_s;
                     if (attempt_inc_s == ATTEMPT_MAX_C) begin
                        state_s = ST_FAIL;
                     end else begin
                        state_s = ST_PULSE_LOW;
                        pulse_s = PULSE_ZERO_C;
                     end
                  end else begin
                     state_s = ST_PULSE_LOW;
                  end
               end else begin
                  state_s = ST_PULSE_HIGH;
               end
            end
            ST_STOP_A: begin
               if (tc_s) state_s = ST_STOP_B;
               else      state_s = ST_STOP_A;
            end
            ST_STOP_B: begin
               if (tc_s) state_s = ST_STOP_C;
               else      state_s = ST_STOP_B;
            end
            ST_STOP_C: begin
               if (tc_s) state_s = ST_DONE;
               else      state_s = ST_STOP_C;
            end
            ST_DONE: begin
               if (i_sda && i_scl) begin
                  recovered_s = 1'b1;
                  state_s     = ST_IDLE;
               end else begin
                  attempt_s = attempt_inc_s;
                  if (attempt_inc_s == ATTEMPT_MAX_C) state_s = ST_FAIL;
                  else                                state_s = ST_START;
               end
            end
            ST_FAIL: begin
               if (!i_stuck) state_s = ST_IDLE;
               else          state_s = ST_FAIL;
            end
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // Timer reload value for the state being entered.
   always_comb begin
      load_val_s = TIMER_ZERO_C;
      case (state_s)
         ST_SCL_CHECK, ST_PULSE_LOW, ST_PULSE_HIGH,
         ST_STOP_A, ST_STOP_B, ST_STOP_C: load_val_s = T_HALF_C;
         ST_PULSE_REL:                    load_val_s = T_STRETCH_C;
         default:                         load_val_s = TIMER_ZERO_C;
      endcase
   end

   // State, timer and counters; a reload on entry takes priority over a tick.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r   <= ST_IDLE;
         timer_r   <= TIMER_ZERO_C;
         pulse_r   <= PULSE_ZERO_C;
         attempt_r <= ATTEMPT_ZERO_C;
      end else begin
         state_r   <= state_s;
         pulse_r   <= pulse_s;
         attempt_r <= attempt_s;
         if (load_s)               timer_r <= load_val_s;
         else if (tick_s && !tc_s) timer_r <= timer_r - TIMER_ONE_C;
         else                      timer_r <= timer_r;
      end
   end

   // Outputs registered from next-state so they line up with the state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_scl_low   <= 1'b0;
         o_sda_low   <= 1'b0;
         o_busy      <= 1'b0;
         o_recovered <= 1'b0;
         o_fail      <= 1'b0;
      end else begin
         o_scl_low   <= (state_s == ST_PULSE_LOW) || (state_s == ST_STOP_A);
         o_sda_low   <= (state_s == ST_STOP_A) || (state_s == ST_STOP_B);
         o_busy      <= (state_s != ST_IDLE) && (state_s != ST_FAIL);
         o_recovered <= recovered_s;
         o_fail      <= (state_s == ST_FAIL);
      end
   end

endmodule

// File: tb/tb_i2c_passthru_bus_recovery.sv
// Directed bench for the bus-recovery sequencer with a simple open-drain bus model
// (T_HALF = 4 ticks, one tick every 4 clocks).
module tb_i2c_passthru_bus_recovery;

   logic clk = 1'b0;
   logic rst, en, f_ref, stuck, scl_hold, sda_hold;
   logic bus_scl, bus_sda;
   logic o_scl_low, o_sda_low, o_busy, o_recovered, o_fail;

   int checks = 0;
   int failures = 0;
   int scl_runs[$];
   int sda_runs[$];
   int scl_run = 0, sda_run = 0, rec_cnt = 0, viol_cnt = 0;
   logic prev_sda_low = 1'b0;

   assign bus_scl = ~(o_scl_low | scl_hold);
   assign bus_sda = ~(o_sda_low | sda_hold);

   i2c_passthru_bus_recovery #(.F_REF_T_HALF(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_f_ref(f_ref), .i_stuck(stuck),
      .i_sda(bus_sda), .i_scl(bus_scl),
      .o_scl_low(o_scl_low), .o_sda_low(o_sda_low), .o_busy(o_busy),
      .o_recovered(o_recovered), .o_fail(o_fail)
   );

   always #5 clk = ~clk;

   initial begin
      f_ref = 1'b0;
      #3;
      forever #20 f_ref = ~f_ref;
   end

   // Record pull-down run lengths (in clocks), strobes and SDA-before-SCL drive order.
   always @(negedge clk) begin
      if (o_scl_low) scl_run++;
      else if (scl_run != 0) begin scl_runs.push_back(scl_run); scl_run = 0; end
      if (o_sda_low) sda_run++;
      else if (sda_run != 0) begin sda_runs.push_back(sda_run); sda_run = 0; end
      if (o_recovered) rec_cnt++;
      if (o_sda_low && !o_scl_low && !prev_sda_low) viol_cnt++;
      prev_sda_low = o_sda_low;
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_mon();
      scl_runs.delete(); sda_runs.delete();
      scl_run = 0; sda_run = 0; rec_cnt = 0; viol_cnt = 0;
   endtask

   task automatic trigger();
      stuck = 1'b0;
      step(2);
      stuck = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; stuck = 1'b0; scl_hold = 1'b0; sda_hold = 1'b0;
      step(3);
      checks++;
      if ({o_scl_low, o_sda_low, o_busy, o_recovered, o_fail} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=00000", {o_scl_low, o_sda_low, o_busy, o_recovered, o_fail});
      end
      rst = 1'b0;
      step(2);
      clear_mon();
   endtask

   task automatic test_recover_3_pulses();
      int n;
      clear_mon();
      sda_hold = 1'b1;
      trigger();
      n = 0;
      while (scl_runs.size() < 3 && n < 2000) begin step(1); n++; end
      sda_hold = 1'b0;
      n = 0;
      while (!o_recovered && n < 2000) begin step(1); n++; end
      checks++;
      if (o_recovered !== 1'b1) begin failures++; $display("FAIL recover_seen got=%b want=1", o_recovered); end
      step(1);
      checks++;
      if (o_recovered !== 1'b0 || rec_cnt != 1) begin
         failures++; $display("FAIL recover_one_clock strobe_clocks=%0d want=1", rec_cnt);
      end
      checks++;
      if (o_busy !== 1'b0 || o_fail !== 1'b0) begin
         failures++; $display("FAIL recover_idle busy=%b fail=%b want=0/0", o_busy, o_fail);
      end
      checks++;
      if (scl_runs.size() != 4) begin
         failures++; $display("FAIL recover_scl_periods got=%0d want=4 (3 pulses + STOP_A)", scl_runs.size());
      end
      foreach (scl_runs[i]) begin
         checks++;
         if (scl_runs[i] < 14 || scl_runs[i] > 17) begin
            failures++; $display("FAIL recover_scl_len[%0d] got=%0d want=14..17", i, scl_runs[i]);
         end
      end
      checks++;
      if (sda_runs.size() != 1 || sda_runs[0] < 28 || sda_runs[0] > 34) begin
         failures++; $display("FAIL recover_sda_stop periods=%0d first_len=%0d want=1 period of 28..34",
                              sda_runs.size(), (sda_runs.size() > 0) ? sda_runs[0] : -1);
      end
      checks++;
      if (viol_cnt != 0) begin failures++; $display("FAIL recover_sda_order violations=%0d want=0", viol_cnt); end
      stuck = 1'b0;
      step(2);
   endtask

   task automatic test_fail_attempts();
      int n;
      clear_mon();
      sda_hold = 1'b1;
      trigger();
      n = 0;
      while (!o_fail && n < 3000) begin step(1); n++; end
      checks++;
      if (o_fail !== 1'b1) begin failures++; $display("FAIL attempts_fail got=%b want=1", o_fail); end
      checks++;
      if (scl_runs.size() != 27 || scl_run != 0) begin
         failures++; $display("FAIL attempts_pulses got=%0d want=27", scl_runs.size());
      end
      checks++;
      if (sda_runs.size() != 0 || sda_run != 0) begin
         failures++; $display("FAIL attempts_no_stop sda_periods=%0d want=0", sda_runs.size());
      end
      checks++;
      if (o_busy !== 1'b0) begin failures++; $display("FAIL attempts_busy got=%b want=0", o_busy); end
      stuck = 1'b0;
      step(1);
      checks++;
      if (o_fail !== 1'b0 || o_busy !== 1'b0) begin
         failures++; $display("FAIL attempts_release fail=%b busy=%b want=0/0", o_fail, o_busy);
      end
      sda_hold = 1'b0;
      step(2);
   endtask

   task automatic test_scl_stuck();
      int n;
      clear_mon();
      scl_hold = 1'b1;
      trigger();
      n = 0;
      while (!o_fail && n < 200) begin step(1); n++; end
      checks++;
      if (o_fail !== 1'b1 || n < 16 || n > 19) begin
         failures++; $display("FAIL scl_stuck_fail fail=%b clocks=%0d want=1 after 16..19", o_fail, n);
      end
      checks++;
      if (scl_runs.size() != 0 || scl_run != 0 || sda_runs.size() != 0 || sda_run != 0) begin
         failures++; $display("FAIL scl_stuck_no_drive scl_periods=%0d sda_periods=%0d want=0/0",
                              scl_runs.size(), sda_runs.size());
      end
      stuck = 1'b0; scl_hold = 1'b0;
      step(2);
   endtask

   task automatic test_stretch();
      int n;
      clear_mon();
      sda_hold = 1'b1;
      trigger();
      n = 0;
      while (!o_scl_low && n < 200) begin step(1); n++; end
      n = 0;
      while (o_scl_low && n < 200) begin step(1); n++; end
      scl_hold = 1'b1;
      step(40);
      checks++;
      if (o_scl_low !== 1'b0 || o_fail !== 1'b0 || o_busy !== 1'b1) begin
         failures++; $display("FAIL stretch_wait scl_low=%b fail=%b busy=%b want=0/0/1", o_scl_low, o_fail, o_busy);
      end
      scl_hold = 1'b0;
      n = 0;
      while (!o_scl_low && n < 100) begin step(1); n++; end
      checks++;
      if (n < 15 || n > 18) begin
         failures++; $display("FAIL stretch_high_phase clocks=%0d want=15..18", n);
      end
      n = 0;
      while (o_scl_low && n < 200) begin step(1); n++; end
      scl_hold = 1'b1;
      n = 0;
      while (!o_fail && n < 1000) begin step(1); n++; end
      checks++;
      if (o_fail !== 1'b1 || n < 797 || n > 800) begin
         failures++; $display("FAIL stretch_timeout fail=%b clocks=%0d want=1 after 797..800", o_fail, n);
      end
      checks++;
      if (o_busy !== 1'b0 || o_scl_low !== 1'b0) begin
         failures++; $display("FAIL stretch_fail_state busy=%b scl_low=%b want=0/0", o_busy, o_scl_low);
      end
      stuck = 1'b0; scl_hold = 1'b0; sda_hold = 1'b0;
      step(2);
   endtask

   task automatic test_en_abort();
      int n;
      clear_mon();
      sda_hold = 1'b1;
      trigger();
      n = 0;
      while (!o_scl_low && n < 200) begin step(1); n++; end
      step(2);
      en = 1'b0;
      step(1);
      checks++;
      if ({o_scl_low, o_sda_low, o_busy, o_fail} !== 4'b0000) begin
         failures++; $display("FAIL en_abort_release got=%b want=0000", {o_scl_low, o_sda_low, o_busy, o_fail});
      end
      step(20);
      checks++;
      if (rec_cnt != 0 || o_busy !== 1'b0) begin
         failures++; $display("FAIL en_abort_idle recovered=%0d busy=%b want=0/0", rec_cnt, o_busy);
      end
      en = 1'b1;
      step(10);
      checks++;
      if (o_busy !== 1'b0 || o_scl_low !== 1'b0) begin
         failures++; $display("FAIL en_no_retrigger busy=%b scl_low=%b want=0/0", o_busy, o_scl_low);
      end
      stuck = 1'b0; sda_hold = 1'b0;
      step(2);
   endtask

   task automatic test_reset_stop_b();
      int n;
      clear_mon();
      sda_hold = 1'b1;
      trigger();
      n = 0;
      while (scl_runs.size() < 1 && n < 500) begin step(1); n++; end
      sda_hold = 1'b0;
      n = 0;
      while (!(o_sda_low && !o_scl_low) && n < 500) begin step(1); n++; end
      checks++;
      if (!(o_sda_low === 1'b1 && o_scl_low === 1'b0)) begin
         failures++; $display("FAIL rst_reach_stop_b sda_low=%b scl_low=%b want=1/0", o_sda_low, o_scl_low);
      end
      rst = 1'b1;
      step(1);
      checks++;
      if ({o_scl_low, o_sda_low, o_busy} !== 3'b000) begin
         failures++; $display("FAIL rst_mid_release got=%b want=000", {o_scl_low, o_sda_low, o_busy});
      end
      rst = 1'b0;
      step(30);
      checks++;
      if (o_busy !== 1'b0 || o_scl_low !== 1'b0) begin
         failures++; $display("FAIL rst_stays_idle busy=%b scl_low=%b want=0/0", o_busy, o_scl_low);
      end
      stuck = 1'b0;
      step(2);
   endtask

   initial begin
      test_reset();
      test_recover_3_pulses();
      test_fail_attempts();
      test_scl_stuck();
      test_stretch();
      test_en_abort();
      test_reset_stop_b();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
